// File: rtl/hpdcache_pkg.sv
// Shared types and helpers for the HPDcache refill path.
//   hpdcache_refill_fsm_e : refill controller state encoding
//   idx_w()               : index width for a table of n entries, never below 1 bit
package hpdcache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    ARB,
    ACK_RD,
    WRITE,
    RSP
  } hpdcache_refill_fsm_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hpdcache_refill_ctrl.sv
// Refill controller: collects memory read-response beats for one outstanding
// miss into a line buffer, acknowledges (frees) the owning MSHR entry through
// the cache pipeline arbiter, writes line + tag into the cache and, when the
// MSHR entry asks for it, returns the requested word to the core.
//   mem_rsp_*   : memory response channel (id = {mshr_way, mshr_set})
//   arb_req/gnt : cache pipeline slot request / grant
//   mshr_ack_*  : MSHR ack/free; mshr_*_i is the entry read back one cycle later
//   refill_*    : one-cycle data+directory write of the assembled line
//   core_rsp_*  : valid/ready response of the requested word to the core
//   busy_o      : controller is not idle
module hpdcache_refill_ctrl
  import hpdcache_pkg::*;
#(
  parameter int unsigned MSHR_SETS  = 4,
  parameter int unsigned MSHR_WAYS  = 4,
  parameter int unsigned SET_W      = 7,
  parameter int unsigned TAG_W      = 20,
  parameter int unsigned WAY_W      = 2,
  parameter int unsigned REQ_ID_W   = 6,
  parameter int unsigned SRC_ID_W   = 3,
  parameter int unsigned WORD_W     = 64,
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned MEM_DATA_W = 128,
  localparam int unsigned MSW    = idx_w(MSHR_SETS),
  localparam int unsigned MWW    = idx_w(MSHR_WAYS),
  localparam int unsigned WIW    = $clog2(LINE_WORDS),
  localparam int unsigned LINE_W = LINE_WORDS * WORD_W
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  mem_rsp_valid_i,
  output logic                  mem_rsp_ready_o,
  input  logic [MWW+MSW-1:0]    mem_rsp_id_i,
  input  logic [MEM_DATA_W-1:0] mem_rsp_data_i,
  input  logic                  mem_rsp_last_i,
  input  logic                  mem_rsp_error_i,
  output logic                  arb_req_o,
  input  logic                  arb_gnt_i,
  output logic                  mshr_ack_o,
  output logic [MSW-1:0]        mshr_ack_set_o,
  output logic [MWW-1:0]        mshr_ack_way_o,
  input  logic [REQ_ID_W-1:0]   mshr_req_id_i,
  input  logic [SRC_ID_W-1:0]   mshr_src_id_i,
  input  logic [SET_W-1:0]      mshr_cache_set_i,
  input  logic [WAY_W-1:0]      mshr_cache_way_i,
  input  logic [TAG_W-1:0]      mshr_cache_tag_i,
  input  logic [WIW-1:0]        mshr_word_i,
  input  logic                  mshr_need_rsp_i,
  input  logic                  mshr_is_prefetch_i,
  output logic                  refill_we_o,
  output logic [SET_W-1:0]      refill_set_o,
  output logic [WAY_W-1:0]      refill_way_o,
  output logic [TAG_W-1:0]      refill_tag_o,
  output logic [LINE_W-1:0]     refill_data_o,
  output logic                  core_rsp_valid_o,
  input  logic                  core_rsp_ready_i,
  output logic [WORD_W-1:0]     core_rsp_data_o,
  output logic [REQ_ID_W-1:0]   core_rsp_tid_o,
  output logic [SRC_ID_W-1:0]   core_rsp_sid_o,
  output logic                  core_rsp_error_o,
  output logic                  busy_o
);

  localparam int unsigned BEATS = LINE_W / MEM_DATA_W;
  // One extra count value marks "buffer full"; further beats are overflow.
  localparam int unsigned CW = $clog2(BEATS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BEATS - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(BEATS);

  hpdcache_refill_fsm_e  state_q;
  logic [CW-1:0]         beat_cnt_q;
  logic                  err_q;
  logic [MSW-1:0]        ack_set_q;
  logic [MWW-1:0]        ack_way_q;
  logic [REQ_ID_W-1:0]   req_id_q;
  logic [SRC_ID_W-1:0]   src_id_q;
  logic [SET_W-1:0]      cset_q;
  logic [WAY_W-1:0]      cway_q;
  logic [TAG_W-1:0]      ctag_q;
  logic [WIW-1:0]        word_q;
  logic                  need_rsp_q;
  logic                  is_pref_q;
  logic [MEM_DATA_W-1:0] line_q [BEATS];

  logic                  receiving;
  logic                  beat_acc;
  logic                  cnt_full;
  logic [LINE_W-1:0]     line_flat;
  logic [WORD_W-1:0]     rsp_word;

  assign receiving = (state_q == IDLE) || (state_q == RECV);
  assign beat_acc  = receiving && mem_rsp_valid_i;
  assign cnt_full  = (beat_cnt_q == CNT_FULL);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
      ack_set_q  <= '0;
      ack_way_q  <= '0;
      req_id_q   <= '0;
      src_id_q   <= '0;
      cset_q     <= '0;
      cway_q     <= '0;
      ctag_q     <= '0;
      word_q     <= '0;
      need_rsp_q <= 1'b0;
      is_pref_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, RECV: begin
          if (mem_rsp_valid_i) begin
            if (state_q == IDLE) begin
              ack_set_q <= mem_rsp_id_i[MSW-1:0];
              ack_way_q <= mem_rsp_id_i[MSW +: MWW];
            end
            if (!cnt_full) beat_cnt_q <= beat_cnt_q + CW'(1);
            // Overflow beats and a premature/late last both poison the line.
            err_q   <= err_q | mem_rsp_error_i | cnt_full
                     | (mem_rsp_last_i & (beat_cnt_q != CNT_LAST));
            state_q <= mem_rsp_last_i ? ARB : RECV;
          end
        end
        ARB: begin
          if (arb_gnt_i) state_q <= ACK_RD;
        end
        ACK_RD: begin
          req_id_q   <= mshr_req_id_i;
          src_id_q   <= mshr_src_id_i;
          cset_q     <= mshr_cache_set_i;
          cway_q     <= mshr_cache_way_i;
          ctag_q     <= mshr_cache_tag_i;
          word_q     <= mshr_word_i;
          need_rsp_q <= mshr_need_rsp_i;
          is_pref_q  <= mshr_is_prefetch_i;
          state_q    <= WRITE;
        end
        WRITE: begin
          if (need_rsp_q && !is_pref_q) begin
            state_q <= RSP;
          end else begin
            state_q    <= IDLE;
            err_q      <= 1'b0;
            beat_cnt_q <= '0;
          end
        end
        RSP: begin
          if (core_rsp_ready_i) begin
            state_q    <= IDLE;
            err_q      <= 1'b0;
            beat_cnt_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Line buffer is pure datapath: stale contents are never exposed because a
  // short or aborted line always ends with err set (no write, zero response).
  always_ff @(posedge clk_i) begin
    for (int unsigned b = 0; b < BEATS; b++) begin
      if (beat_acc && (beat_cnt_q == CW'(b))) line_q[b] <= mem_rsp_data_i;
    end
  end

  always_comb begin
    line_flat = '0;
    for (int unsigned b = 0; b < BEATS; b++) begin
      line_flat[b*MEM_DATA_W +: MEM_DATA_W] = line_q[b];
    end
    rsp_word = '0;
    for (int unsigned w = 0; w < LINE_WORDS; w++) begin
      if (word_q == WIW'(w)) rsp_word = line_flat[w*WORD_W +: WORD_W];
    end
  end

  assign mem_rsp_ready_o  = receiving;
  assign arb_req_o        = (state_q == ARB);
  assign mshr_ack_o       = (state_q == ARB) && arb_gnt_i;
  assign mshr_ack_set_o   = ack_set_q;
  assign mshr_ack_way_o   = ack_way_q;
  assign refill_we_o      = (state_q == WRITE) && !err_q;
  assign refill_set_o     = cset_q;
  assign refill_way_o     = cway_q;
  assign refill_tag_o     = ctag_q;
  assign refill_data_o    = (state_q == WRITE) ? line_flat : '0;
  assign core_rsp_valid_o = (state_q == RSP);
  assign core_rsp_data_o  = ((state_q == RSP) && !err_q) ? rsp_word : '0;
  assign core_rsp_tid_o   = req_id_q;
  assign core_rsp_sid_o   = src_id_q;
  assign core_rsp_error_o = (state_q == RSP) && err_q;
  assign busy_o           = (state_q != IDLE);

endmodule
